// File: rtl/peak_dpu_dsp_scb_if.sv
// peak_dpu_dsp_scb_if: decode-to-dispatch bundle, writeback release and grant signals
interface peak_dpu_dsp_scb_if #(
  parameter int ISS_W = 2,
  parameter int AW    = 5,
  parameter int NWB   = 3
);
  logic                dsp_rdy;
  logic                flush;
  logic [ISS_W-1:0]    slot_vld;
  logic [ISS_W-1:0]    slot_rs0_vld;
  logic [ISS_W-1:0]    slot_rs1_vld;
  logic [ISS_W*AW-1:0] slot_rs0_addr;
  logic [ISS_W*AW-1:0] slot_rs1_addr;
  logic [ISS_W-1:0]    slot_rd_vld;
  logic [ISS_W*AW-1:0] slot_rd_addr;
  logic [ISS_W*2-1:0]  slot_cls;
  logic [ISS_W-1:0]    slot_is_br;
  logic [NWB-1:0]      wb_vld;
  logic [NWB*AW-1:0]   wb_addr;
  logic [2:0]          unit_busy;
  logic [ISS_W-1:0]    slot_iss;
  modport master (
    output dsp_rdy, flush, slot_vld, slot_rs0_vld, slot_rs1_vld, slot_rs0_addr, slot_rs1_addr,
           slot_rd_vld, slot_rd_addr, slot_cls, slot_is_br, wb_vld, wb_addr, unit_busy,
    input  slot_iss
  );
  modport slave (
    input  dsp_rdy, flush, slot_vld, slot_rs0_vld, slot_rs1_vld, slot_rs0_addr, slot_rs1_addr,
           slot_rd_vld, slot_rd_addr, slot_cls, slot_is_br, wb_vld, wb_addr, unit_busy,
    output slot_iss
  );
endinterface

// File: rtl/peak_dpu_dsp_scb.sv
// peak_dpu_dsp_scb: in-order ISS_W-slot dispatch with long-latency pending scoreboard
// Ports: clk, rst (sync, active-high); bus (slave: bundle in, writebacks in, slot_iss out);
// pend_vec (registered pending registers); stall_cnt (saturating slot-0 stall cycles).
// Option: PEAK_DPU_SCB_WB_BYPASS_EN lets a same-cycle writeback release a RAW source.
module peak_dpu_dsp_scb #(
  parameter int ISS_W = 2,
  parameter int NREG  = 32,
  parameter int AW    = 5,
  parameter int NWB   = 3,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  peak_dpu_dsp_scb_if.slave  bus,
  output logic [NREG-1:0]    pend_vec,
  output logic [CNT_W-1:0]   stall_cnt
);
  localparam int NR = 1 << AW;
  logic [AW-1:0] rs0 [ISS_W];
  logic [AW-1:0] rs1 [ISS_W];
  logic [AW-1:0] rd  [ISS_W];
  logic [1:0]    cls [ISS_W];
  logic [AW-1:0] wba [NWB];
  logic [NR-1:0] pend_w, clr, set, rel;
  logic [ISS_W-1:0] haz, iss;
  logic [3:0] busy_c;
  logic ok;
  for (genvar k = 0; k < ISS_W; k++) begin : g_slot
    assign rs0[k] = bus.slot_rs0_addr[k*AW +: AW];
    assign rs1[k] = bus.slot_rs1_addr[k*AW +: AW];
    assign rd[k]  = bus.slot_rd_addr[k*AW +: AW];
    assign cls[k] = bus.slot_cls[k*2 +: 2];
  end
  for (genvar w = 0; w < NWB; w++) begin : g_wb
    assign wba[w] = bus.wb_addr[w*AW +: AW];
  end
  assign pend_w = NR'(pend_vec);
  // class 0 has no unit, so index 0 of this vector is a constant "not busy"
  assign busy_c = {bus.unit_busy, 1'b0};
  always_comb begin
    clr = '0;
    for (int i = 0; i < NWB; i++)
      if (bus.wb_vld[i]) clr[wba[i]] = 1'b1;
  end
`ifdef PEAK_DPU_SCB_WB_BYPASS_EN
  assign rel = clr;
`else
  assign rel = '0;
`endif
  always_comb begin
    haz = '0;
    iss = '0;
    set = '0;
    ok  = bus.dsp_rdy && !bus.flush;
    for (int k = 0; k < ISS_W; k++) begin
      haz[k] = (bus.slot_rs0_vld[k] && rs0[k] != '0 && pend_w[rs0[k]] && !rel[rs0[k]]) ||
               (bus.slot_rs1_vld[k] && rs1[k] != '0 && pend_w[rs1[k]] && !rel[rs1[k]]) ||
               (bus.slot_rd_vld[k]  && rd[k]  != '0 && pend_w[rd[k]]) ||
               busy_c[cls[k]];
      for (int j = 0; j < k; j++)
        if (bus.slot_vld[j])
          haz[k] = haz[k] ||
                   (bus.slot_rd_vld[j] && rd[j] != '0 &&
                    (rd[j] == rs0[k] || rd[j] == rs1[k] || rd[j] == rd[k])) ||
                   (cls[j] != 2'd0 && cls[j] == cls[k]) ||
                   bus.slot_is_br[j];
      // each grant also gates every younger slot, keeping issue in order
      iss[k] = ok && bus.slot_vld[k] && !haz[k];
      ok     = iss[k];
      if (iss[k] && cls[k] != 2'd0 && bus.slot_rd_vld[k] && rd[k] != '0) set[rd[k]] = 1'b1;
    end
  end
  assign bus.slot_iss = iss;
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_vec  <= '0;
      stall_cnt <= '0;
    end else begin
      pend_vec <= NREG'((pend_w & ~clr) | set);
      if (bus.slot_vld[0] && bus.dsp_rdy && !bus.flush && !iss[0] && !(&stall_cnt))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_peak_dpu_dsp_scb.sv
// tb_peak_dpu_dsp_scb: directed vectors with a queue scoreboard for grants, pending and stalls
module tb_peak_dpu_dsp_scb;
  localparam int ISS_W = 2, NREG = 32, AW = 5, NWB = 3, CNT_W = 4;
`ifdef PEAK_DPU_SCB_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int S = BYP ? 1 : 2;
  typedef struct {
    string       name;
    logic [1:0]  iss;
    logic [31:0] pend;
    int          stall;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [NREG-1:0] pend_vec;
  logic [CNT_W-1:0] stall_cnt;
  int checks = 0, errors = 0;
  exp_t q[$];
  peak_dpu_dsp_scb_if #(.ISS_W(ISS_W), .AW(AW), .NWB(NWB)) bus ();
  peak_dpu_dsp_scb #(.ISS_W(ISS_W), .NREG(NREG), .AW(AW), .NWB(NWB), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus), .pend_vec(pend_vec), .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks += 3;
      if (bus.slot_iss !== e.iss) begin
        errors++;
        $display("FAIL %s slot_iss got %b want %b", e.name, bus.slot_iss, e.iss);
      end
      if (pend_vec !== e.pend) begin
        errors++;
        $display("FAIL %s pend_vec got %h want %h", e.name, pend_vec, e.pend);
      end
      if (int'(stall_cnt) != e.stall) begin
        errors++;
        $display("FAIL %s stall_cnt got %0d want %0d", e.name, stall_cnt, e.stall);
      end
    end
  end
  task automatic idle();
    bus.dsp_rdy = 1'b1; bus.flush = 1'b0; bus.slot_vld = '0; bus.slot_rs0_vld = '0;
    bus.slot_rs1_vld = '0; bus.slot_rs0_addr = '0; bus.slot_rs1_addr = '0; bus.slot_rd_vld = '0;
    bus.slot_rd_addr = '0; bus.slot_cls = '0; bus.slot_is_br = '0; bus.wb_vld = '0;
    bus.wb_addr = '0; bus.unit_busy = '0;
  endtask
  task automatic slot(input int k, input bit r0v, input int r0, input bit r1v, input int r1,
                      input bit dv, input int d, input int c, input bit br);
    bus.slot_vld[k] = 1'b1;
    bus.slot_rs0_vld[k] = r0v; bus.slot_rs0_addr[k*AW +: AW] = AW'(r0);
    bus.slot_rs1_vld[k] = r1v; bus.slot_rs1_addr[k*AW +: AW] = AW'(r1);
    bus.slot_rd_vld[k] = dv;   bus.slot_rd_addr[k*AW +: AW] = AW'(d);
    bus.slot_cls[k*2 +: 2] = 2'(c); bus.slot_is_br[k] = br;
  endtask
  task automatic wb(input int i, input int a);
    bus.wb_vld[i] = 1'b1;
    bus.wb_addr[i*AW +: AW] = AW'(a);
  endtask
  task automatic step(input string n, input logic [1:0] i, input logic [31:0] p, input int s);
    q.push_back('{n, i, p, s});
    @(posedge clk); #1;
  endtask
  initial begin
    idle();
    @(posedge clk); #1;
    step("reset", 2'b00, 32'h0, 0);
    rst = 1'b0;
    idle(); slot(0, 0, 0, 0, 0, 1, 5, 3, 0); slot(1, 1, 5, 0, 0, 1, 6, 0, 0);
    step("ld_raw_bundle", 2'b01, 32'h0, 0);
    idle(); slot(0, 1, 5, 0, 0, 1, 6, 0, 0);
    step("raw_stall", 2'b00, 32'h20, 0);
    wb(0, 5);
    step("raw_wb_cycle", BYP ? 2'b01 : 2'b00, 32'h20, 1);
    idle(); slot(0, 1, 5, 0, 0, 1, 6, 0, 0);
    step("raw_released", 2'b01, 32'h0, S);
    idle(); slot(0, 0, 0, 0, 0, 1, 10, 1, 0); slot(1, 0, 0, 0, 0, 1, 11, 1, 0);
    step("mul_mul", 2'b01, 32'h0, S);
    idle(); slot(0, 0, 0, 0, 0, 1, 12, 1, 0); bus.unit_busy = 3'b001;
    step("mul_busy", 2'b00, 32'h400, S);
    idle(); wb(0, 10);
    step("stall_inc", 2'b00, 32'h400, S + 1);
    idle(); slot(0, 0, 0, 0, 0, 0, 0, 0, 1); slot(1, 0, 0, 0, 0, 1, 3, 0, 0);
    step("br_alu", 2'b01, 32'h0, S + 1);
    idle(); slot(0, 0, 0, 0, 0, 1, 7, 2, 0);
    step("div_x7", 2'b01, 32'h0, S + 1);
    idle(); slot(0, 1, 7, 0, 0, 1, 8, 0, 0); slot(1, 1, 1, 0, 0, 1, 2, 0, 0);
    step("raw_x7_blocks_all", 2'b00, 32'h80, S + 1);
    idle(); slot(0, 0, 0, 0, 0, 1, 9, 2, 0); wb(0, 7); wb(1, 9); wb(2, 7);
    step("div_x9_with_wb", 2'b01, 32'h80, S + 2);
    idle();
    step("set_wins", 2'b00, 32'h200, S + 2);
    idle(); bus.flush = 1'b1; slot(0, 0, 0, 0, 0, 1, 4, 0, 0); slot(1, 0, 0, 0, 0, 1, 13, 1, 0);
    step("flush", 2'b00, 32'h200, S + 2);
    idle(); slot(0, 0, 0, 0, 0, 1, 9, 0, 0);
    step("waw_after_flush", 2'b00, 32'h200, S + 2);
    idle(); slot(0, 1, 0, 0, 0, 1, 0, 1, 0); wb(0, 20);
    step("x0_mul", 2'b01, 32'h200, S + 3);
    idle(); bus.dsp_rdy = 1'b0; slot(0, 0, 0, 0, 0, 1, 14, 1, 0);
    step("no_rdy", 2'b00, 32'h200, S + 3);
    idle();
    step("idle_after", 2'b00, 32'h200, S + 3);
    idle(); slot(0, 0, 0, 0, 0, 1, 9, 0, 0);
    for (int i = 0; i < (1 << CNT_W) + 3; i++)
      step("saturate", 2'b00, 32'h200, (S + 3 + i > 15) ? 15 : S + 3 + i);
    step("sat_hold", 2'b00, 32'h200, 15);
    rst = 1'b1;
    step("rst_cycle", 2'b00, 32'h200, 15);
    rst = 1'b0; wb(0, 9);
    step("post_rst", 2'b01, 32'h0, 0);
    idle();
    step("late_wb_harmless", 2'b00, 32'h0, 0);
    for (int t = 0; t < 10 && q.size() > 0; t++) @(posedge clk);
    if (q.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain queue left %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
